// File: rtl/prog_pkg.sv
// Shared widths and FSM state encoding for the program-memory loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prog_pkg;

    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 16;
    localparam int MEM_DEPTH = 1 << ADDR_W;
    localparam int BYTE_W    = 8;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_LOAD_HI = 3'd1,
        ST_LOAD_LO = 3'd2,
        ST_WRITE   = 3'd3,
        ST_FINISH  = 3'd4
    } state_t;

endpackage

// File: rtl/prog_word_packer.sv
// Assembles two received bytes (high byte first) into one instruction word.
// Latency: each byte appears in o_word one clk after its load strobe.
// Backpressure: none; the strobes come from the controller FSM phase.
module prog_word_packer
    import prog_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_hi_we,
    input  logic                  i_lo_we,
    input  logic [BYTE_W-1:0]     i_byte,
    output logic [2*BYTE_W-1:0]   o_word
);

    logic [BYTE_W-1:0] r_hi_byte;
    logic [BYTE_W-1:0] r_lo_byte;

    // Capture whichever half of the word the controller says is on the wire.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hi_byte <= '0;
            r_lo_byte <= '0;
        end else begin
            if (i_hi_we) r_hi_byte <= i_byte;
            if (i_lo_we) r_lo_byte <= i_byte;
        end
    end

    assign o_word = {r_hi_byte, r_lo_byte};

endmodule

// File: rtl/prog_mem_ctrl.sv
// Muxes the program RAM between CPU fetch (RUN) and a UART byte-stream loader.
// Latency: fetch data one clk after cpu_addr; a word is written one clk after its low byte.
// Backpressure: none; bytes arriving outside a receiving phase are dropped.
module prog_mem_ctrl
    import prog_pkg::*;
#(
    parameter int ADDR_W = prog_pkg::ADDR_W,
    parameter int DATA_W = prog_pkg::DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load_en,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_cpu_reset,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_we,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [ADDR_W:0]   o_word_count,
    output logic              o_load_done,
    output logic              o_overrun
);

    localparam logic [ADDR_W-1:0] PTR_MAX = '1;
    localparam logic [ADDR_W:0]   WC_MAX  = {1'b1, {ADDR_W{1'b0}}};

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W:0]     r_word_count;
    logic                r_overrun;
    logic                w_hi_we;
    logic                w_lo_we;
    logic [15:0]         w_word;

    // High byte is taken in LOAD_HI, or in WRITE when the next word starts back-to-back;
    // a byte coinciding with load_en falling is deliberately ignored.
    assign w_hi_we = i_rx_valid && (((r_state == ST_LOAD_HI) && i_load_en) || (r_state == ST_WRITE));
    assign w_lo_we = i_rx_valid && (r_state == ST_LOAD_LO) && i_load_en;

    prog_word_packer u_packer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_hi_we (w_hi_we),
        .i_lo_we (w_lo_we),
        .i_byte  (i_rx_data),
        .o_word  (w_word)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_RUN;
        else          r_state <= w_next;
    end

    // Next-state decode; WRITE always lasts one clk regardless of load_en.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RUN:     if (i_load_en) w_next = ST_LOAD_HI;
            ST_LOAD_HI: begin
                if (!i_load_en)      w_next = ST_FINISH;
                else if (i_rx_valid) w_next = ST_LOAD_LO;
            end
            ST_LOAD_LO: begin
                if (!i_load_en)      w_next = ST_FINISH;
                else if (i_rx_valid) w_next = ST_WRITE;
            end
            ST_WRITE:   w_next = i_rx_valid ? ST_LOAD_LO : ST_LOAD_HI;
            ST_FINISH:  w_next = ST_RUN;
            default:    w_next = ST_RUN;
        endcase
    end

    // Outputs decoded from the registered state only.
    always_comb begin
        o_cpu_reset = (r_state != ST_RUN);
        o_mem_addr  = (r_state == ST_RUN) ? i_cpu_addr : r_wr_ptr;
        o_mem_we    = (r_state == ST_WRITE);
        o_load_done = (r_state == ST_FINISH);
        o_mem_wdata = DATA_W'(w_word);
        o_cpu_rdata = i_mem_rdata;
    end

    // Write pointer, saturating word count and sticky wrap flag; cleared when a load starts.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr     <= '0;
            r_word_count <= '0;
            r_overrun    <= 1'b0;
        end else if ((r_state == ST_RUN) && i_load_en) begin
            r_wr_ptr     <= '0;
            r_word_count <= '0;
            r_overrun    <= 1'b0;
        end else if (r_state == ST_WRITE) begin
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (r_word_count != WC_MAX) r_word_count <= r_word_count + (ADDR_W+1)'(1);
            if (r_wr_ptr == PTR_MAX)    r_overrun    <= 1'b1;
        end
    end

    assign o_word_count = r_word_count;
    assign o_overrun    = r_overrun;

endmodule

// File: doc/prog_mem_ctrl.md
PROG_MEM_CTRL -- requirements
Module: prog_mem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 12, SHALL set the program memory address width.
REQ-002 Parameter DATA_W, default 16, SHALL set the instruction word width.
REQ-003 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 load_en  in  1  SHALL request load mode while high (synchronised level from the board switch).
REQ-006 rx_valid  in  1  SHALL be a one-clk pulse marking a received UART byte.
REQ-007 rx_data  in  8  SHALL be the received byte, valid when rx_valid=1.
REQ-008 cpu_addr  in  ADDR_W  SHALL be the CPU instruction fetch address.
REQ-009 cpu_rdata  out  DATA_W  SHALL be the fetched instruction word.
REQ-010 cpu_reset  out  1  SHALL hold the CPU in reset while high.
REQ-011 mem_addr  out  ADDR_W, mem_wdata  out  DATA_W, mem_we  out  1 SHALL drive the single-port synchronous program RAM.
REQ-012 mem_rdata  in  DATA_W  SHALL be the RAM read data, one clk after mem_addr.
REQ-013 word_count  out  ADDR_W+1  SHALL be the number of words written in the current or last load.
REQ-014 load_done  out  1  SHALL pulse for one clk when a load session ends.
REQ-015 overrun  out  1  SHALL be a sticky flag: the write address wrapped during the current or last load.

Function
REQ-016 States SHALL be RUN, LOAD_HI, LOAD_LO, WRITE, FINISH.
REQ-017 RUN: mem_addr=cpu_addr, mem_we=0, cpu_rdata=mem_rdata, cpu_reset=0; load_en=1 SHALL move to LOAD_HI and clear wr_ptr, word_count and overrun on that edge.
REQ-018 In every state other than RUN, cpu_reset SHALL be 1 and mem_addr SHALL be wr_ptr.
REQ-019 LOAD_HI: load_en=0 SHALL move to FINISH and ignore any coincident rx_valid; otherwise rx_valid SHALL latch rx_data into hi_byte and move to LOAD_LO.
REQ-020 LOAD_LO: load_en=0 SHALL move to FINISH and discard the half word; otherwise rx_valid SHALL latch lo_byte and move to WRITE.
REQ-021 WRITE SHALL last exactly one clk with mem_we=1 and mem_wdata={hi_byte,lo_byte}, high byte first on the wire.
REQ-022 On leaving WRITE: wr_ptr SHALL increment modulo 2^ADDR_W, and word_count SHALL increment, saturating at 2^ADDR_W.
REQ-023 A write with wr_ptr=2^ADDR_W-1 SHALL set overrun.
REQ-024 rx_valid during WRITE SHALL be latched as hi_byte, with transition to LOAD_LO; otherwise WRITE SHALL return to LOAD_HI, regardless of load_en.
REQ-025 FINISH SHALL last one clk with load_done=1, then go to RUN; cpu_reset SHALL fall on entry to RUN.
REQ-026 mem_we SHALL be 1 only in WRITE, decoded from registered state.

Reset
REQ-027 rst_n=0 SHALL immediately force state=RUN, and clear wr_ptr, hi_byte, lo_byte, word_count, overrun and load_done to 0.
REQ-028 Reset asserted mid-load SHALL abort without a further write; RAM contents SHALL be left as written.
REQ-029 After reset release, a held load_en=1 SHALL start a new load on the first clk edge.

Structure
REQ-030 Package prog_pkg SHALL hold ADDR_W, DATA_W, MEM_DEPTH and the state enum type.
REQ-031 One sub-module, prog_word_packer (byte pair to 16-bit word, with hi/lo phase), is natural; the FSM, pointer and counters SHALL stay in prog_mem_ctrl.

Verification
REQ-032 load_en=1, bytes A1 B2 C3 D4, load_en=0 -> writes 16'hA1B2@0 and 16'hC3D4@1, word_count=2, one load_done pulse, cpu_reset low after FINISH.
REQ-033 Bytes 12 34 56, then load_en=0 -> only 16'h1234@0 is written, word_count=1, half word discarded.
REQ-034 4097 words streamed -> word 4096 is written at addr 0, overrun=1, word_count=4096.
REQ-035 RUN with preloaded RAM, cpu_addr=5 -> cpu_rdata equals mem[5] one clk later, and mem_we stays 0.
REQ-036 rst_n pulled low in LOAD_LO after byte 7F -> RUN next, no write, all counters 0.
REQ-037 rx_valid in the same clk as load_en falling in LOAD_HI -> byte ignored, FINISH entered, no write.
